// File: rtl/frame_decode.sv
// Receive-side frame decoder: reassembles the Rx bit stream into LSB-first bytes,
// strips/checks odd parity and emits a partial final byte for short/anticollision frames.
module frame_decode #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_data,
  input  logic       in_data_valid,
  input  logic       in_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic [2:0] out_bits,
  output logic       out_soc,
  output logic       out_eoc,
  output logic       out_error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       par_q, par_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_bits_q, out_bits_d;
  logic       out_soc_q, out_soc_d;
  logic       out_eoc_q, out_eoc_d;
  logic       out_error_q, out_error_d;

  // Next-state and output decode; strobe priority is soc > eoc > error > data_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_bits_d  = out_bits_q;
    out_soc_d   = in_soc;
    out_eoc_d   = 1'b0;
    out_error_d = out_error_q;

    if (in_soc) begin
      state_d     = ST_DATA;
      cnt_d       = 3'd0;
      sr_d        = 8'd0;
      par_d       = 1'b1;
      out_error_d = 1'b0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (in_eoc) begin
            out_eoc_d = 1'b1;
            state_d   = ST_IDLE;
            if (cnt_q != 3'd0) begin
              out_valid_d = 1'b1;
              out_bits_d  = cnt_q;
              out_data_d  = sr_q;
            end
          end else if (in_error) begin
            out_error_d = 1'b1;
            state_d     = ST_ERROR;
          end else if (in_data_valid) begin
            sr_d[cnt_q] = in_data;
            par_d       = par_q ^ in_data;
            cnt_d       = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (in_eoc) begin
            // Eight data bits with no parity bit following: byte is kept but flagged.
            out_eoc_d   = 1'b1;
            out_valid_d = 1'b1;
            out_bits_d  = 3'd0;
            out_data_d  = sr_q;
            out_error_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (in_error) begin
            out_error_d = 1'b1;
            state_d     = ST_ERROR;
          end else if (in_data_valid) begin
            out_valid_d = 1'b1;
            out_bits_d  = 3'd0;
            out_data_d  = sr_q;
            if (CHECK_PARITY && (in_data != par_q)) begin
              out_error_d = 1'b1;
              state_d     = ST_ERROR;
            end else begin
              state_d = ST_DATA;
              par_d   = 1'b1;
              sr_d    = 8'd0;
              cnt_d   = 3'd0;
            end
          end
        end
        ST_ERROR: begin
          if (in_eoc) begin
            out_eoc_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 8'd0;
      par_q       <= 1'b1;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_bits_q  <= 3'd0;
      out_soc_q   <= 1'b0;
      out_eoc_q   <= 1'b0;
      out_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      par_q       <= par_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_soc_q   <= out_soc_d;
      out_eoc_q   <= out_eoc_d;
      out_error_q <= out_error_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_soc   = out_soc_q;
  assign out_eoc   = out_eoc_q;
  assign out_error = out_error_q;

endmodule

// File: tb/tb_frame_decode.sv
// Bench for frame_decode: parity-checking and non-checking instances driven in parallel,
// compared against a frame-level model of the byte/parity/partial-byte rules.
module tb_frame_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_soc = 1'b0, in_eoc = 1'b0, in_data = 1'b0, in_data_valid = 1'b0, in_error = 1'b0;

  logic [7:0] out_data_a, out_data_b;
  logic [2:0] out_bits_a, out_bits_b;
  logic out_valid_a, out_soc_a, out_eoc_a, out_error_a;
  logic out_valid_b, out_soc_b, out_eoc_b, out_error_b;

  int total = 0;
  int bad = 0;

  bit          tx_bits[$];
  logic [11:0] got_a[$], got_b[$], cur_a[$], cur_b[$], exp_t[$], exp_a[$], exp_b[$], lit[$];
  logic        err_t, xerr_a, xerr_b;
  int          eoc_a = 0, eoc_b = 0, soc_a = 0, soc_b = 0;

  always #5 clk = ~clk;

  frame_decode #(.CHECK_PARITY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_bits(out_bits_a), .out_soc(out_soc_a),
    .out_eoc(out_eoc_a), .out_error(out_error_a)
  );

  frame_decode #(.CHECK_PARITY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_bits(out_bits_b), .out_soc(out_soc_b),
    .out_eoc(out_eoc_b), .out_error(out_error_b)
  );

  // Output log: each emitted byte recorded as {eoc_same_cycle, bits, data}.
  always @(negedge clk) begin
    if (out_valid_a) got_a.push_back({out_eoc_a, out_bits_a, out_data_a});
    if (out_valid_b) got_b.push_back({out_eoc_b, out_bits_b, out_data_b});
    if (out_eoc_a) eoc_a++;
    if (out_eoc_b) eoc_b++;
    if (out_soc_a) soc_a++;
    if (out_soc_b) soc_b++;
  end

  function automatic logic [103:0] pack_q(input logic [11:0] q[$]);
    logic [103:0] r = '0;
    for (int i = 0; i < q.size() && i < 8; i++) r[i*12 +: 12] = q[i];
    r[103:96] = 8'(q.size());
    return r;
  endfunction

  task automatic drive(input bit soc, input bit eoc, input bit dv, input bit d, input bit err);
    @(negedge clk);
    in_soc = soc; in_eoc = eoc; in_data_valid = dv; in_data = d; in_error = err;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit p);
    for (int k = 0; k < 8; k++) tx_bits.push_back(d[k]);
    tx_bits.push_back(p);
  endtask

  task automatic send_bits();
    for (int i = 0; i < tx_bits.size(); i++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, tx_bits[i], 1'b0);
    end
  endtask

  // Frame-level model: 9-bit groups (8 data + odd parity), then a trailing partial group.
  task automatic model(input bit chk, input bit eoc);
    int i;
    int rem;
    logic [7:0] d;
    exp_t.delete();
    err_t = 1'b0;
    i = 0;
    while (1) begin
      rem = tx_bits.size() - i;
      d = 8'd0;
      for (int k = 0; k < 8 && k < rem; k++) d[k] = tx_bits[i+k];
      if (rem >= 9) begin
        exp_t.push_back({1'b0, 3'd0, d});
        if (chk && (tx_bits[i+8] != ~^d)) begin
          err_t = 1'b1;
          break;
        end
        i += 9;
      end else begin
        if (eoc && rem == 8) begin
          exp_t.push_back({1'b1, 3'd0, d});
          err_t = 1'b1;
        end else if (eoc && rem > 0) begin
          exp_t.push_back({1'b1, 3'(rem), d});
        end
        break;
      end
    end
  endtask

  // Scenario runner: soc (optionally with a same-cycle bit), tx_bits, optional eoc.
  task automatic run_frame(input string name, input bit do_eoc, input int soc_dv);
    int ba, bb, ea0, eb0, sa0, sb0;
    logic [103:0] pg, px;
    idle(2);
    ba = got_a.size(); bb = got_b.size();
    ea0 = eoc_a; eb0 = eoc_b; sa0 = soc_a; sb0 = soc_b;
    if (soc_dv < 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    else drive(1'b1, 1'b0, 1'b1, 1'(soc_dv), 1'b0);
    send_bits();
    if (do_eoc) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    model(1'b1, do_eoc); exp_a = exp_t; xerr_a = err_t;
    model(1'b0, do_eoc); exp_b = exp_t; xerr_b = err_t;
    cur_a.delete(); cur_b.delete();
    for (int i = ba; i < got_a.size(); i++) cur_a.push_back(got_a[i]);
    for (int i = bb; i < got_b.size(); i++) cur_b.push_back(got_b[i]);

    pg = pack_q(cur_a); px = pack_q(exp_a);
    total++; if (pg !== px) begin bad++; $display("FAIL %s bytes_chk got=%h exp=%h", name, pg, px); end
    pg = pack_q(cur_b); px = pack_q(exp_b);
    total++; if (pg !== px) begin bad++; $display("FAIL %s bytes_nochk got=%h exp=%h", name, pg, px); end
    total++; if (eoc_a - ea0 != int'(do_eoc)) begin bad++; $display("FAIL %s eoc_chk got=%0d exp=%0d", name, eoc_a - ea0, do_eoc); end
    total++; if (eoc_b - eb0 != int'(do_eoc)) begin bad++; $display("FAIL %s eoc_nochk got=%0d exp=%0d", name, eoc_b - eb0, do_eoc); end
    total++; if (soc_a - sa0 != 1 || soc_b - sb0 != 1) begin bad++; $display("FAIL %s soc got=%0d/%0d exp=1", name, soc_a - sa0, soc_b - sb0); end
    total++; if (out_error_a !== xerr_a) begin bad++; $display("FAIL %s err_chk got=%b exp=%b", name, out_error_a, xerr_a); end
    total++; if (out_error_b !== xerr_b) begin bad++; $display("FAIL %s err_nochk got=%b exp=%b", name, out_error_b, xerr_b); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if ({out_valid_a, out_eoc_a, out_soc_a, out_error_a, out_bits_a, out_data_a} !== 15'd0) begin
      bad++; $display("FAIL reset_chk got=%h exp=0", {out_valid_a, out_eoc_a, out_soc_a, out_error_a, out_bits_a, out_data_a}); end
    total++; if ({out_valid_b, out_eoc_b, out_soc_b, out_error_b, out_bits_b, out_data_b} !== 15'd0) begin
      bad++; $display("FAIL reset_nochk got=%h exp=0", {out_valid_b, out_eoc_b, out_soc_b, out_error_b, out_bits_b, out_data_b}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reqa();
    tx_bits = '{0, 1, 1, 0, 0, 1, 0};
    run_frame("reqa", 1'b1, -1);
    lit = '{12'hF26};
    total++; if (pack_q(cur_a) !== pack_q(lit)) begin bad++; $display("FAIL reqa_const got=%h exp=%h", pack_q(cur_a), pack_q(lit)); end
  endtask

  task automatic test_sel();
    tx_bits.delete();
    push_byte(8'h93, 1'b1);
    push_byte(8'h20, 1'b0);
    run_frame("sel_nvb", 1'b1, -1);
    lit = '{12'h093, 12'h020};
    total++; if (pack_q(cur_a) !== pack_q(lit)) begin bad++; $display("FAIL sel_const got=%h exp=%h", pack_q(cur_a), pack_q(lit)); end
  endtask

  task automatic test_parity_err();
    tx_bits.delete();
    push_byte(8'h93, 1'b0);
    for (int k = 0; k < 9; k++) tx_bits.push_back(1'($urandom));
    run_frame("parity_err", 1'b1, -1);
    lit = '{12'h093};
    total++; if (pack_q(cur_a) !== pack_q(lit)) begin bad++; $display("FAIL parity_const got=%h exp=%h", pack_q(cur_a), pack_q(lit)); end
    idle(4);
    total++; if (out_error_a !== 1'b1 || out_error_b !== 1'b0) begin
      bad++; $display("FAIL parity_hold got=%b/%b exp=1/0", out_error_a, out_error_b); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (out_error_a !== 1'b0) begin bad++; $display("FAIL parity_clear got=%b exp=0", out_error_a); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic test_anticoll();
    tx_bits.delete();
    push_byte(8'h93, 1'b1);
    push_byte(8'h70, 1'b0);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    run_frame("anticoll", 1'b1, -1);
    lit = '{12'h093, 12'h070, 12'hB05};
    total++; if (pack_q(cur_a) !== pack_q(lit)) begin bad++; $display("FAIL anticoll_const got=%h exp=%h", pack_q(cur_a), pack_q(lit)); end
  endtask

  task automatic test_abort();
    tx_bits.delete();
    push_byte(8'h5A, ~^8'h5A);
    for (int k = 0; k < 3; k++) tx_bits.push_back(1'($urandom));
    run_frame("abort_old", 1'b0, -1);
    tx_bits.delete();
    push_byte(8'hC3, ~^8'hC3);
    run_frame("abort_new", 1'b1, -1);
  endtask

  task automatic test_in_error();
    int ba, bb, ea0, eb0;
    idle(2);
    ba = got_a.size(); bb = got_b.size(); ea0 = eoc_a; eb0 = eoc_b;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    total++; if (got_a.size() != ba || got_b.size() != bb) begin
      bad++; $display("FAIL in_error_bytes got=%0d/%0d exp=0", got_a.size() - ba, got_b.size() - bb); end
    total++; if (eoc_a - ea0 != 1 || eoc_b - eb0 != 1) begin
      bad++; $display("FAIL in_error_eoc got=%0d/%0d exp=1", eoc_a - ea0, eoc_b - eb0); end
    total++; if (out_error_a !== 1'b1 || out_error_b !== 1'b1) begin
      bad++; $display("FAIL in_error_flag got=%b/%b exp=1/1", out_error_a, out_error_b); end
  endtask

  task automatic test_missing_parity();
    tx_bits.delete();
    for (int k = 0; k < 8; k++) tx_bits.push_back(1'($urandom));
    run_frame("missing_parity", 1'b1, -1);
  endtask

  task automatic test_soc_same_cycle();
    tx_bits = '{0, 1, 1, 0, 0, 1, 0};
    run_frame("soc_dv", 1'b1, 1);
    lit = '{12'hF26};
    total++; if (pack_q(cur_a) !== pack_q(lit)) begin bad++; $display("FAIL soc_dv_const got=%h exp=%h", pack_q(cur_a), pack_q(lit)); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int nb;
      int nt;
      logic [7:0] d;
      nb = $urandom_range(0, 3);
      nt = $urandom_range(0, 8);
      tx_bits.delete();
      for (int b = 0; b < nb; b++) begin
        d = 8'($urandom);
        push_byte(d, (~^d) ^ ($urandom_range(0, 4) == 0));
      end
      for (int k = 0; k < nt; k++) tx_bits.push_back(1'($urandom));
      run_frame("random", 1'b1, -1);
    end
  endtask

  task automatic test_reset_mid();
    int ba, bb, ea0, eb0;
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_data_valid = 1'b1; in_data = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_data_valid = 1'b0; in_data = 1'b0;
    total++; if ({out_valid_a, out_eoc_a, out_soc_a, out_error_a, out_bits_a, out_data_a} !== 15'd0) begin
      bad++; $display("FAIL rst_mid_chk got=%h exp=0", {out_valid_a, out_eoc_a, out_soc_a, out_error_a, out_bits_a, out_data_a}); end
    total++; if ({out_valid_b, out_eoc_b, out_soc_b, out_error_b, out_bits_b, out_data_b} !== 15'd0) begin
      bad++; $display("FAIL rst_mid_nochk got=%h exp=0", {out_valid_b, out_eoc_b, out_soc_b, out_error_b, out_bits_b, out_data_b}); end
    ba = got_a.size(); bb = got_b.size(); ea0 = eoc_a; eb0 = eoc_b;
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    total++; if (got_a.size() != ba || got_b.size() != bb) begin
      bad++; $display("FAIL rst_mid_bytes got=%0d/%0d exp=0", got_a.size() - ba, got_b.size() - bb); end
    total++; if (eoc_a != ea0 || eoc_b != eb0) begin
      bad++; $display("FAIL rst_mid_eoc got=%0d/%0d exp=0", eoc_a - ea0, eoc_b - eb0); end
  endtask

  initial begin
    test_reset();
    test_reqa();
    test_sel();
    test_parity_err();
    test_anticoll();
    test_abort();
    test_in_error();
    test_missing_parity();
    test_soc_same_cycle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
